interval_timer: RTL and testbench
=================================

// Module: interval_timer
// PURPOSE
//  Countdown timer at the far end of the traffic-light controller's timing interface.
//  - Consumes start_t/interval from the controller; returns a one-cycle expired pulse
//    after the selected number of seconds.
//  - Holds three runtime-programmable durations (base, extended, yellow).
//  - Sits between the synchronizers and the controller FSM, sharing clk and reset_sync.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per 1 s tick (benches use 4)
//  T_BASE    4'd6         default base duration, seconds
//  T_EXT     4'd3         default extended duration, seconds
//  T_YEL     4'd2         default yellow duration, seconds
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  reset_sync  in   1  synchronous active-high reset
//  prog_sync   in   1  write strobe: load time_value into register selected by param_sel
//  param_sel   in   2  00 base, 01 extended, 10 yellow, 11 ignored
//  time_value  in   4  seconds to program; 0 means "restore default"
//  start_t     in   1  start/restart countdown using interval
//  interval    in   2  00 base, 01 extended, 10 yellow, 11 treated as base
//  expired     out  1  one-cycle pulse at terminal count
// BEHAVIOUR
//  Reset (reset_sync=1, takes priority over everything):
//   - regs <= T_BASE/T_EXT/T_YEL; state IDLE; count 0; divider 0; expired 0.
//  Programming:
//   - prog_sync=1 writes reg[param_sel] <= (time_value==0 ? default : time_value).
//   - sel 11 is a no-op.
//   - A running countdown is unaffected; the new value applies from the next start_t.
//  FSM states and transitions:
//   - IDLE: expired=0. start_t -> COUNT.
//   - COUNT: decrements once per tick. Reaching terminal count -> IDLE.
//  Start (any state):
//   - start_t samples interval in that cycle.
//   - count <= reg[interval]; divider <= 0.
//  Tick and expiry:
//   - Tick fires when divider == TICK_DIV-1; divider wraps to 0; count decrements.
//   - Tick that takes count 1->0 registers expired=1 for exactly one cycle.
//  Latency:
//   - start_t sampled at edge N with duration T s -> expired high in cycle N+T*TICK_DIV.
//  Simultaneous events:
//   - start_t in the same cycle as the terminal tick: expired still pulses; reload wins;
//     state COUNT.
//   - start_t and prog_sync together: start uses the OLD register value.
//   - reset_sync with any input: reset wins; expired=0 next cycle.
//  Other rules:
//   - start_t asserted on consecutive cycles: each cycle restarts the countdown.
//   - Register width is 4 bits; max duration 15 s. There is no zero-length interval.
//   - Tick counter width is $clog2(TICK_DIV); TICK_DIV=1 means every cycle is a tick.
// CONFIGURATION
//  INTERVAL_TIMER_REMAIN_EN
//   - Defined: adds output remaining [3:0] = current count (seconds left) for the display.
//     It reads 0 in IDLE and after reset, and updates in the same cycle as count.
//   - Undefined: port and logic absent; behaviour otherwise identical.
// STRUCTURE
//  Package traffic_pkg:
//   - INT_BASE=2'b00, INT_EXT=2'b01, INT_YEL=2'b10.
//   - PSEL_* encodings (same values).
//   - Timer state enum {IDLE, COUNT}.
//  Sub-module tick_gen:
//   - 1 s enable generator; inputs clk, reset_sync, restart (=start_t); output tick.
//   - Parameter TICK_DIV.
// TESTING (TICK_DIV=4)
//  1. Reset, start_t with interval=00 -> expired single pulse exactly 24 cycles later;
//     none before or after.
//  2. prog_sync sel=10 value=5, then start_t interval=10 -> expired after 20 cycles;
//     then value=0 -> next yellow run is 8 cycles (default restored).
//  3. start_t int=01 (12 cycles); re-assert start_t int=10 at cycle 6 -> expired 8 cycles
//     after the second start, none at cycle 12.
//  4. prog_sync sel=00 value=9 mid-count of a base run -> current run still expires at
//     24; next base run 36.
//  5. reset_sync at cycle 10 of a countdown -> no expired; regs back to defaults;
//     IDLE until start_t.
//  6. Run with INTERVAL_TIMER_REMAIN_EN: remaining steps 6,5,...,1,0 at each tick;
//     expired coincides with 0. Build without the macro: same expired timing.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller's timing interface:
// interval / parameter-select codes, timer state enum and a code-folding helper.
package traffic_pkg;

    localparam logic [1:0] INT_BASE  = 2'b00;
    localparam logic [1:0] INT_EXT   = 2'b01;
    localparam logic [1:0] INT_YEL   = 2'b10;

    localparam logic [1:0] PSEL_BASE = 2'b00;
    localparam logic [1:0] PSEL_EXT  = 2'b01;
    localparam logic [1:0] PSEL_YEL  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } timer_state_e;

    // Interval code 11 has no register of its own and runs the base duration.
    function automatic logic [1:0] interval_idx(input logic [1:0] iv);
        return (iv == 2'b11) ? INT_BASE : iv;
    endfunction

endpackage

// File: rtl/interval_timer_if.sv
// Controller <-> interval timer bus. The controller is the master (programs
// durations, starts countdowns); the timer is the slave (returns expired).
// Optional `remaining` display output exists only with INTERVAL_TIMER_REMAIN_EN.
interface interval_timer_if;

    logic       prog_sync;
    logic [1:0] param_sel;
    logic [3:0] time_value;
    logic       start_t;
    logic [1:0] interval;
    logic       expired;
`ifdef INTERVAL_TIMER_REMAIN_EN
    logic [3:0] remaining;

    modport master (
        output prog_sync, param_sel, time_value, start_t, interval,
        input  expired, remaining
    );
    modport slave (
        input  prog_sync, param_sel, time_value, start_t, interval,
        output expired, remaining
    );
`else
    modport master (
        output prog_sync, param_sel, time_value, start_t, interval,
        input  expired
    );
    modport slave (
        input  prog_sync, param_sel, time_value, start_t, interval,
        output expired
    );
`endif

endinterface

// File: rtl/tick_gen.sv
// One-second enable generator: pulses `tick` every TICK_DIV cycles and is
// re-phased to zero by `restart` so each countdown gets whole seconds.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset_sync,
    input  logic restart,
    output logic tick
);

    // TICK_DIV=1 would give a zero-width counter; keep one bit that stays 0.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_q;

    assign tick = (div_q == DIV_LAST);

    // Next divider value: restart and wrap both return to zero.
    always_comb begin
        div_d = div_q;
        if (restart) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Countdown timer serving the traffic-light controller. Holds three
// programmable durations (base/extended/yellow, 0 restores the default),
// counts the selected one down in 1 s ticks and pulses `expired` for one cycle.
// Optional feature macro: INTERVAL_TIMER_REMAIN_EN adds bus.remaining.
module interval_timer
    import traffic_pkg::*;
#(
    parameter int         TICK_DIV = 100_000_000,
    parameter logic [3:0] T_BASE   = 4'd6,
    parameter logic [3:0] T_EXT    = 4'd3,
    parameter logic [3:0] T_YEL    = 4'd2
) (
    input  logic           clk,
    input  logic           reset_sync,
    interval_timer_if.slave bus
);

    logic [3:0]   reg_base_d, reg_base_q;
    logic [3:0]   reg_ext_d,  reg_ext_q;
    logic [3:0]   reg_yel_d,  reg_yel_q;
    logic [3:0]   count_d,    count_q;
    logic         expired_d,  expired_q;
    timer_state_e state_d,    state_q;
    logic [3:0]   start_val_s;
    logic         tick_s;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk        (clk),
        .reset_sync (reset_sync),
        .restart    (bus.start_t),
        .tick       (tick_s)
    );

    // Duration register writes; a zero value restores the build-time default.
    always_comb begin
        reg_base_d = reg_base_q;
        reg_ext_d  = reg_ext_q;
        reg_yel_d  = reg_yel_q;
        if (bus.prog_sync) begin
            case (bus.param_sel)
                PSEL_BASE: reg_base_d = (bus.time_value == 4'd0) ? T_BASE : bus.time_value;
                PSEL_EXT:  reg_ext_d  = (bus.time_value == 4'd0) ? T_EXT  : bus.time_value;
                PSEL_YEL:  reg_yel_d  = (bus.time_value == 4'd0) ? T_YEL  : bus.time_value;
                default:   ;
            endcase
        end else begin
            reg_base_d = reg_base_q;
        end
    end

    // Reload value from the registers as they stand now (old value on a simultaneous write).
    always_comb begin
        start_val_s = reg_base_q;
        case (interval_idx(bus.interval))
            INT_EXT: start_val_s = reg_ext_q;
            INT_YEL: start_val_s = reg_yel_q;
            default: start_val_s = reg_base_q;
        endcase
    end

    // Countdown FSM next state; a start overrides the tick's reload but not its expiry pulse.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        if ((state_q == COUNT) && tick_s) begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
                expired_d = 1'b1;
                state_d   = IDLE;
            end else begin
                state_d   = COUNT;
            end
        end else begin
            count_d = count_q;
        end
        if (bus.start_t) begin
            state_d = COUNT;
            count_d = start_val_s;
        end else begin
            state_d = state_d;
        end
    end

    // State, count, output and duration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            expired_q  <= 1'b0;
            reg_base_q <= T_BASE;
            reg_ext_q  <= T_EXT;
            reg_yel_q  <= T_YEL;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            reg_base_q <= reg_base_d;
            reg_ext_q  <= reg_ext_d;
            reg_yel_q  <= reg_yel_d;
        end
    end

    assign bus.expired = expired_q;
`ifdef INTERVAL_TIMER_REMAIN_EN
    assign bus.remaining = count_q;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer (TICK_DIV=4). A deadline-based
// reference model predicts the expiry cycle of each countdown; every cycle
// the DUT output is compared against it, plus directed latency checks.
module tb_interval_timer;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset_sync;
    always #5 clk = ~clk;

    interval_timer_if bus();

    interval_timer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int regs [3];
    int defs [3];
    int dl;
    bit dl_v;
    int npulse;
    int dut_last;
    int s;

    // Advance one clock, update the model for the inputs sampled at that edge, compare.
    task automatic step();
        bit e;
        int rem_exp;
        @(posedge clk);
        #1;
        cyc++;
        e = !reset_sync && dl_v && (dl == cyc);
        if (dl_v && dl <= cyc) dl_v = 1'b0;
        if (reset_sync) begin
            for (int i = 0; i < 3; i++) regs[i] = defs[i];
            dl_v = 1'b0;
        end else begin
            if (bus.start_t) begin
                dl   = cyc + TD * regs[(bus.interval == 2'b11) ? 0 : int'(bus.interval)];
                dl_v = 1'b1;
            end
            if (bus.prog_sync && bus.param_sel != 2'b11)
                regs[bus.param_sel] = (bus.time_value == 4'd0) ? defs[bus.param_sel] : int'(bus.time_value);
        end
        if (bus.expired === 1'b1) begin
            npulse++;
            dut_last = cyc;
        end
        total++;
        assert (bus.expired === e) else begin
            bad++;
            $error("FAIL expired cyc=%0d observed=%b expected=%b", cyc, bus.expired, e);
        end
`ifdef INTERVAL_TIMER_REMAIN_EN
        rem_exp = dl_v ? (dl - cyc + TD - 1) / TD : 0;
        total++;
        assert (bus.remaining === 4'(rem_exp)) else begin
            bad++;
            $error("FAIL remaining cyc=%0d observed=%0d expected=%0d", cyc, bus.remaining, rem_exp);
        end
`else
        rem_exp = 0;
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start(input logic [1:0] iv);
        bus.start_t  = 1'b1;
        bus.interval = iv;
        step();
        bus.start_t  = 1'b0;
        s = cyc;
    endtask

    task automatic do_prog(input logic [1:0] sel, input logic [3:0] v);
        bus.prog_sync  = 1'b1;
        bus.param_sel  = sel;
        bus.time_value = v;
        step();
        bus.prog_sync  = 1'b0;
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        defs[0] = 6; defs[1] = 3; defs[2] = 2;
        for (int i = 0; i < 3; i++) regs[i] = defs[i];
        dl_v = 1'b0; dl = 0;
        bus.prog_sync = 1'b0; bus.param_sel = 2'b00; bus.time_value = 4'd0;
        bus.start_t = 1'b0; bus.interval = 2'b00;

        // Reset state
        reset_sync = 1'b1;
        run(3);
        reset_sync = 1'b0;
        run(2);

        // 1: base run expires exactly 24 cycles after start
        npulse = 0; dut_last = -1;
        do_start(2'b00);
        run(32);
        check_int("t1_time", dut_last, s + 24);
        check_int("t1_pulses", npulse, 1);

        // 2: programmed yellow 5 s -> 20 cycles; then zero restores 2 s -> 8
        do_prog(2'b10, 4'd5);
        npulse = 0; dut_last = -1;
        do_start(2'b10);
        run(24);
        check_int("t2_prog", dut_last, s + 20);
        do_prog(2'b10, 4'd0);
        npulse = 0; dut_last = -1;
        do_start(2'b10);
        run(12);
        check_int("t2_default", dut_last, s + 8);

        // 3: restart mid-count with yellow; only the second countdown expires
        npulse = 0; dut_last = -1;
        do_start(2'b01);
        run(5);
        do_start(2'b10);
        run(14);
        check_int("t3_time", dut_last, s + 8);
        check_int("t3_pulses", npulse, 1);

        // 4: reprogramming base mid-count leaves the current run alone
        npulse = 0; dut_last = -1;
        do_start(2'b00);
        run(4);
        do_prog(2'b00, 4'd9);
        run(22);
        check_int("t4_cur", dut_last, s + 24);
        do_start(2'b11);
        run(40);
        check_int("t4_next", dut_last, s + 36);

        // 5: reset mid-count kills expiry and restores base to 6 s
        npulse = 0; dut_last = -1;
        do_start(2'b00);
        run(9);
        reset_sync = 1'b1;
        step();
        reset_sync = 1'b0;
        run(40);
        check_int("t5_pulses", npulse, 0);
        do_start(2'b00);
        run(28);
        check_int("t5_default", dut_last, s + 24);

        // Simultaneous start and program: start uses the old extended value (3 s)
        bus.prog_sync = 1'b1; bus.param_sel = 2'b01; bus.time_value = 4'd7;
        do_start(2'b01);
        bus.prog_sync = 1'b0;
        run(16);
        check_int("old_value", dut_last, s + 12);

        // Random phase checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            reset_sync     = ($urandom_range(0, 99) == 0);
            bus.start_t    = ($urandom_range(0, 15) == 0);
            bus.interval   = 2'($urandom_range(0, 3));
            bus.prog_sync  = ($urandom_range(0, 9) == 0);
            bus.param_sel  = 2'($urandom_range(0, 3));
            bus.time_value = 4'($urandom_range(0, 15));
            step();
        end
        reset_sync = 1'b0; bus.start_t = 1'b0; bus.prog_sync = 1'b0;
        run(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
